// File: rtl/pc_exception_sequencer.sv
// PC-path owner for the multicycle datapath: forwards main-control PC requests in IDLE and
// sequences exception entry (EPC save, vector fetch, PC load) and RTE. Option: EXC_NEST_LOCK_EN.
module pc_exception_sequencer #(
   parameter int         MEM_LAT    = 1,
   parameter logic [7:0] VEC_OPCODE = 8'd253,
   parameter logic [7:0] VEC_OVF    = 8'd254,
   parameter logic [7:0] VEC_DIV    = 8'd255
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [2:0] pc_src_req_i,
   input  logic       pc_write_req_i,
   input  logic       exc_opcode_i,
   input  logic       exc_overflow_i,
   input  logic       exc_divzero_i,
   input  logic       rte_req_i,
   output logic [2:0] pc_source_o,
   output logic       pc_write_o,
   output logic       epc_write_o,
   output logic       alu_epc_sel_o,
   output logic       exc_addr_sel_o,
   output logic [7:0] exc_mem_addr_o,
   output logic       mem_read_o,
   output logic       busy_o,
   output logic       in_handler_o,
   output logic [1:0] exc_cause_o
`ifdef EXC_NEST_LOCK_EN
   ,
   output logic       double_fault_o
`endif
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SAVE_EPC = 3'd1;
   localparam logic [2:0] S_FETCH    = 3'd2;
   localparam logic [2:0] S_LOAD_PC  = 3'd3;
   localparam logic [2:0] S_RTE      = 3'd4;

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   logic [2:0]    state_q, state_d;
   logic [1:0]    cause_q, cause_d;
   logic [1:0]    pend_q, pend_d;
   logic          in_handler_q, in_handler_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    vec_q, vec_d;
   logic          exc_any;
   logic          take_exc;
   logic [1:0]    req_cause;

   assign exc_any = exc_opcode_i | exc_overflow_i | exc_divzero_i;

   always_comb begin
      req_cause = 2'd3;
      if (exc_opcode_i)
         req_cause = 2'd1;
      else if (exc_overflow_i)
         req_cause = 2'd2;
   end

`ifdef EXC_NEST_LOCK_EN
   logic df_q, df_d;
   assign take_exc       = exc_any & ~in_handler_q;
   assign double_fault_o = df_q;
`else
   assign take_exc = exc_any;
`endif

   function automatic logic [7:0] vec_of(input logic [1:0] c);
      case (c)
         2'd1:    vec_of = VEC_OPCODE;
         2'd2:    vec_of = VEC_OVF;
         default: vec_of = VEC_DIV;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      pend_d       = pend_q;
      in_handler_d = in_handler_q;
      cnt_d        = cnt_q;
      vec_d        = vec_q;
`ifdef EXC_NEST_LOCK_EN
      df_d         = df_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (take_exc) begin
               pend_d  = req_cause;
               state_d = S_SAVE_EPC;
            end
`ifdef EXC_NEST_LOCK_EN
            else if (exc_any)
               df_d = 1'b1;
`endif
            else if (rte_req_i)
               state_d = S_RTE;
         end
         S_SAVE_EPC: begin
            cause_d      = pend_q;
            in_handler_d = 1'b1;
            cnt_d        = CW'(MEM_LAT - 1);
            vec_d        = vec_of(pend_q);
            state_d      = S_FETCH;
         end
         S_FETCH: begin
            if (cnt_q == '0)
               state_d = S_LOAD_PC;
            else
               cnt_d = cnt_q - CW'(1);
         end
         S_LOAD_PC: state_d = S_IDLE;
         S_RTE: begin
            in_handler_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= S_IDLE;
         cause_q      <= 2'd0;
         pend_q       <= 2'd0;
         in_handler_q <= 1'b0;
         cnt_q        <= '0;
         vec_q        <= 8'd0;
`ifdef EXC_NEST_LOCK_EN
         df_q         <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         pend_q       <= pend_d;
         in_handler_q <= in_handler_d;
         cnt_q        <= cnt_d;
         vec_q        <= vec_d;
`ifdef EXC_NEST_LOCK_EN
         df_q         <= df_d;
`endif
      end
   end

   // Strobes are gated by reset so the IDLE pass-through cannot leak while reset is held.
   always_comb begin
      pc_source_o    = 3'd0;
      pc_write_o     = 1'b0;
      epc_write_o    = 1'b0;
      alu_epc_sel_o  = 1'b0;
      exc_addr_sel_o = 1'b0;
      mem_read_o     = 1'b0;
      busy_o         = 1'b0;
      if (reset_n_i) begin
         case (state_q)
            S_IDLE: begin
               if (pc_src_req_i <= 3'd4) begin
                  pc_source_o = pc_src_req_i;
                  pc_write_o  = pc_write_req_i & ~exc_any;
               end
            end
            S_SAVE_EPC: begin
               epc_write_o   = 1'b1;
               alu_epc_sel_o = 1'b1;
               busy_o        = 1'b1;
            end
            S_FETCH: begin
               exc_addr_sel_o = 1'b1;
               mem_read_o     = 1'b1;
               busy_o         = 1'b1;
            end
            S_LOAD_PC: begin
               pc_source_o = 3'd3;
               pc_write_o  = 1'b1;
               busy_o      = 1'b1;
            end
            S_RTE: begin
               pc_source_o = 3'd4;
               pc_write_o  = 1'b1;
               busy_o      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign exc_mem_addr_o = vec_q;
   assign exc_cause_o    = cause_q;
   assign in_handler_o   = in_handler_q;

endmodule

// File: tb/tb_pc_exception_sequencer.sv
// Scoreboard bench for pc_exception_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus;
// expected output vectors are queued per cycle and compared on the falling edge.
module tb_pc_exception_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] pc_src_req;
   logic       pc_write_req, exc_opcode, exc_overflow, exc_divzero, rte_req;

   logic [2:0] src1, src3;
   logic       pw1, ew1, aes1, eas1, mr1, busy1, inh1;
   logic       pw3, ew3, aes3, eas3, mr3, busy3, inh3;
   logic [7:0] addr1, addr3;
   logic [1:0] cause1, cause3;
`ifdef EXC_NEST_LOCK_EN
   logic       df1, df3;
`endif

   always #5 clk = ~clk;

   pc_exception_sequencer #(.MEM_LAT(1)) u1 (
      .clk_i(clk), .reset_n_i(reset_n), .pc_src_req_i(pc_src_req), .pc_write_req_i(pc_write_req),
      .exc_opcode_i(exc_opcode), .exc_overflow_i(exc_overflow), .exc_divzero_i(exc_divzero),
      .rte_req_i(rte_req), .pc_source_o(src1), .pc_write_o(pw1), .epc_write_o(ew1),
      .alu_epc_sel_o(aes1), .exc_addr_sel_o(eas1), .exc_mem_addr_o(addr1), .mem_read_o(mr1),
      .busy_o(busy1), .in_handler_o(inh1), .exc_cause_o(cause1)
`ifdef EXC_NEST_LOCK_EN
      , .double_fault_o(df1)
`endif
   );

   pc_exception_sequencer #(.MEM_LAT(3)) u3 (
      .clk_i(clk), .reset_n_i(reset_n), .pc_src_req_i(pc_src_req), .pc_write_req_i(pc_write_req),
      .exc_opcode_i(exc_opcode), .exc_overflow_i(exc_overflow), .exc_divzero_i(exc_divzero),
      .rte_req_i(rte_req), .pc_source_o(src3), .pc_write_o(pw3), .epc_write_o(ew3),
      .alu_epc_sel_o(aes3), .exc_addr_sel_o(eas3), .exc_mem_addr_o(addr3), .mem_read_o(mr3),
      .busy_o(busy3), .in_handler_o(inh3), .exc_cause_o(cause3)
`ifdef EXC_NEST_LOCK_EN
      , .double_fault_o(df3)
`endif
   );

   logic [19:0] o1, o3;
   assign o1 = {src1, pw1, ew1, aes1, eas1, mr1, busy1, inh1, cause1, addr1};
   assign o3 = {src3, pw3, ew3, aes3, eas3, mr3, busy3, inh3, cause3, addr3};

   int n_checks = 0;
   int n_err    = 0;

   logic [19:0] exp_q[$];
   string       tag_q[$];
   bit          sel_q[$];

   // Expected architectural state tracked by the bench from the observed request history.
   logic       m_inh;
   logic [1:0] m_cause;
   logic [7:0] m_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic [2:0] src, input logic pw, input logic ew,
                                      input logic aes, input logic eas, input logic mr,
                                      input logic busy, input logic inh, input logic [1:0] c,
                                      input logic [7:0] a);
      return {src, pw, ew, aes, eas, mr, busy, inh, c, a};
   endfunction

   function automatic logic [7:0] vec(input logic [1:0] c);
      return (c == 2'd1) ? 8'd253 : (c == 2'd2) ? 8'd254 : 8'd255;
   endfunction

   task automatic step(input string tag, input bit sel, input logic [19:0] exp);
      logic [19:0] e;
      string       t;
      bit          s;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      $display("[%0t] %-14s lat=%0d obs=%h exp=%h", $time, t, s ? 3 : 1, s ? o3 : o1, e);
      check(t, {12'd0, (s ? o3 : o1)}, {12'd0, e});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives a request cycle with exc_* already set by the caller, then walks the entry sequence.
   task automatic exc_run(input string tag, input bit sel, input int lat, input logic [1:0] c);
      pc_src_req = 3'd1; pc_write_req = 1'b1;
      step({tag, "_req"}, sel, mk(3'd1, 0, 0, 0, 0, 0, 0, m_inh, m_cause, m_addr));
      exc_opcode = 0; exc_overflow = 0; exc_divzero = 0; rte_req = 0;
      step({tag, "_save"}, sel, mk(3'd0, 0, 1, 1, 0, 0, 1, m_inh, m_cause, m_addr));
      m_inh = 1'b1; m_cause = c; m_addr = vec(c);
      for (int i = 0; i < lat; i++)
         step({tag, "_fetch"}, sel, mk(3'd0, 0, 0, 0, 1, 1, 1, 1'b1, c, m_addr));
      step({tag, "_load"}, sel, mk(3'd3, 1, 0, 0, 0, 0, 1, 1'b1, c, m_addr));
      step({tag, "_idle"}, sel, mk(3'd1, 1, 0, 0, 0, 0, 0, 1'b1, c, m_addr));
      pc_src_req = 3'd0; pc_write_req = 1'b0;
      idle(4);
   endtask

   task automatic rte_run(input string tag, input bit sel);
      pc_src_req = 3'd0; pc_write_req = 1'b0; rte_req = 1'b1;
      step({tag, "_req"}, sel, mk(3'd0, 0, 0, 0, 0, 0, 0, m_inh, m_cause, m_addr));
      rte_req = 1'b0;
      step({tag, "_rte"}, sel, mk(3'd4, 1, 0, 0, 0, 0, 1, m_inh, m_cause, m_addr));
      m_inh = 1'b0;
      step({tag, "_done"}, sel, mk(3'd0, 0, 0, 0, 0, 0, 0, 1'b0, m_cause, m_addr));
      idle(2);
   endtask

   initial begin
      reset_n = 1'b0;
      pc_src_req = 3'd2; pc_write_req = 1'b1;
      exc_opcode = 0; exc_overflow = 0; exc_divzero = 0; rte_req = 0;
      m_inh = 1'b0; m_cause = 2'd0; m_addr = 8'd0;
      idle(3);
      step("reset_l1", 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      step("reset_l3", 1, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
`ifdef EXC_NEST_LOCK_EN
      check("df_reset", {31'd0, df1}, 32'd0);
`endif
      reset_n = 1'b1;
      step("pass_l1", 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      step("pass_l3", 1, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      pc_src_req = 3'd4;
      step("pass_src4", 0, mk(3'd4, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      pc_src_req = 3'd6;
      step("illegal6", 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      pc_src_req = 3'd7; pc_write_req = 1'b0;
      step("illegal7", 1, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      pc_src_req = 3'd5; pc_write_req = 1'b1;
      step("illegal5", 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));

      exc_overflow = 1'b1;
      exc_run("ovf", 0, 1, 2'd2);

`ifdef EXC_NEST_LOCK_EN
      exc_overflow = 1'b1; pc_src_req = 3'd1; pc_write_req = 1'b1;
      step("nest_req", 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 1'b1, 2'd2, 8'd254));
      exc_overflow = 1'b0;
      step("nest_stay", 0, mk(3'd1, 1, 0, 0, 0, 0, 0, 1'b1, 2'd2, 8'd254));
      check("nest_df", {31'd0, df1}, 32'd1);
      pc_src_req = 3'd0; pc_write_req = 1'b0;
      idle(4);
      check("nest_df_hold", {31'd0, df1}, 32'd1);
`else
      exc_overflow = 1'b1;
      exc_run("nest", 0, 1, 2'd2);
`endif

      rte_run("rte", 0);

      rte_req = 1'b1; exc_divzero = 1'b1;
      exc_run("rte_div", 0, 1, 2'd3);
      rte_run("rte2", 1);

      exc_opcode = 1'b1; exc_divzero = 1'b1;
      exc_run("prio", 1, 3, 2'd1);
      rte_run("rte3", 1);

      // Abort in the middle of the 3-cycle fetch.
      exc_overflow = 1'b1; pc_src_req = 3'd1; pc_write_req = 1'b1;
      step("abort_req", 1, mk(3'd1, 0, 0, 0, 0, 0, 0, m_inh, m_cause, m_addr));
      exc_overflow = 1'b0;
      step("abort_save", 1, mk(3'd0, 0, 1, 1, 0, 0, 1, m_inh, m_cause, m_addr));
      step("abort_fetch", 1, mk(3'd0, 0, 0, 0, 1, 1, 1, 1'b1, 2'd2, 8'd254));
      reset_n = 1'b0; pc_src_req = 3'd2; pc_write_req = 1'b1;
      m_inh = 1'b0; m_cause = 2'd0; m_addr = 8'd0;
      step("abort_rst", 1, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      step("abort_rst_l1", 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
`ifdef EXC_NEST_LOCK_EN
      check("df_cleared", {31'd0, df1}, 32'd0);
`endif
      reset_n = 1'b1;
      step("post_rst", 1, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
      step("post_rst_l1", 0, mk(3'd2, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
